// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with skid buffer, flush and stall counter
//
// Purpose:
//   Two-entry pipeline stage between EX and MEM. The main entry drives the
//   outputs; the skid entry absorbs one extra transfer so that InReady can be
//   a pure register with no combinational path from OutReady.
//
// Parameters:
//   DATA_W  width of ALU result and store data
//   REG_W   width of destination register index
//   CNT_W   width of the saturating stall counter
//
// Ports:
//   Clock, Reset                 rising-edge clock, synchronous active-high reset
//   Flush                        drop both held entries and the current input
//   InValid / InReady            upstream (EX) handshake, InReady registered
//   MemWriteIn .. RegWriteIn     control bits from EX
//   WriteRegisterIn              destination register index
//   ALUResultIn, StoreDataIn     payload from EX
//   MemWriteOut .. StoreDataOut  payload of the main entry toward MEM
//   OutValid / OutReady          downstream (MEM) handshake
//   StallCount                   saturating count of OutValid & ~OutReady cycles
//
// Optional feature (macro EX_MEM_STAGE_FWD_EN):
//   FwdSrcA, FwdSrcB             source register indices to compare
//   FwdHitA, FwdHitB             forwarding hit per source
//   FwdData                      value to forward (ALUResultOut)

module ex_mem_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Flush,
   input  logic              InValid,
   output logic              InReady,
   input  logic              MemWriteIn,
   input  logic              MemReadIn,
   input  logic              BranchIn,
   input  logic              MemToRegIn,
   input  logic              RegWriteIn,
   input  logic [REG_W-1:0]  WriteRegisterIn,
   input  logic [DATA_W-1:0] ALUResultIn,
   input  logic [DATA_W-1:0] StoreDataIn,
   output logic              MemWriteOut,
   output logic              MemReadOut,
   output logic              BranchOut,
   output logic              MemToRegOut,
   output logic              RegWriteOut,
   output logic [REG_W-1:0]  WriteRegisterOut,
   output logic [DATA_W-1:0] ALUResultOut,
   output logic [DATA_W-1:0] StoreDataOut,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [CNT_W-1:0]  StallCount
`ifdef EX_MEM_STAGE_FWD_EN
   ,
   input  logic [REG_W-1:0]  FwdSrcA,
   input  logic [REG_W-1:0]  FwdSrcB,
   output logic              FwdHitA,
   output logic              FwdHitB,
   output logic [DATA_W-1:0] FwdData
`endif
);

   // Packed entry layout, MSB first:
   //   MemWrite, MemRead, Branch, MemToReg, RegWrite, WriteRegister, ALUResult, StoreData
   localparam int PW       = 5 + REG_W + 2 * DATA_W;
   localparam int SD_LSB   = 0;
   localparam int ALU_LSB  = DATA_W;
   localparam int WREG_LSB = 2 * DATA_W;
   localparam int RW_BIT   = 2 * DATA_W + REG_W;
   localparam int M2R_BIT  = RW_BIT + 1;
   localparam int BR_BIT   = RW_BIT + 2;
   localparam int MR_BIT   = RW_BIT + 3;
   localparam int MW_BIT   = RW_BIT + 4;

   logic [PW-1:0]    in_entry;
   logic [PW-1:0]    main_entry;
   logic [PW-1:0]    skid_entry;
   logic             main_valid;
   logic             skid_valid;
   logic             in_ready_q;
   logic [CNT_W-1:0] stall_cnt;

   logic             accept;
   logic             rel;
   logic             stall;
   logic             stall_sat;

   assign in_entry = {MemWriteIn, MemReadIn, BranchIn, MemToRegIn, RegWriteIn,
                      WriteRegisterIn, ALUResultIn, StoreDataIn};

   assign accept    = InValid & in_ready_q;
   assign rel       = main_valid & OutReady;
   assign stall     = main_valid & ~OutReady;
   assign stall_sat = (stall_cnt == {CNT_W{1'b1}});

   // Entry storage and handshake state.
   // in_ready_q always equals ~skid_valid; it is kept as its own flop so the
   // upstream ready is a clean register output.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         main_entry <= '0;
         skid_entry <= '0;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready_q <= 1'b1;
      end else if (Flush) begin
         // Payload is left in place; invalidation alone hides it because
         // the side-effecting control outputs are gated with OutValid.
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready_q <= 1'b1;
      end else if (rel) begin
         if (skid_valid) begin
            // Skid refills main; no accept is possible here since
            // in_ready_q is low whenever the skid entry is full.
            main_entry <= skid_entry;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
         end else if (accept) begin
            main_entry <= in_entry;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         if (main_valid) begin
            skid_entry <= in_entry;
            skid_valid <= 1'b1;
            in_ready_q <= 1'b0;
         end else begin
            main_entry <= in_entry;
            main_valid <= 1'b1;
         end
      end
   end

   // Stall counter ignores Flush so flush storms still show up as stalls.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         stall_cnt <= '0;
      end else if (stall && !stall_sat) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign InReady          = in_ready_q;
   assign OutValid         = main_valid;
   assign StallCount       = stall_cnt;

   assign MemWriteOut      = main_valid & main_entry[MW_BIT];
   assign MemReadOut       = main_valid & main_entry[MR_BIT];
   assign BranchOut        = main_valid & main_entry[BR_BIT];
   assign MemToRegOut      = main_entry[M2R_BIT];
   assign WriteRegisterOut = main_entry[WREG_LSB +: REG_W];
   assign ALUResultOut     = main_entry[ALU_LSB +: DATA_W];
   assign StoreDataOut     = main_entry[SD_LSB +: DATA_W];

   // Register 0 is hardwired, so a write to it is never reported.
   assign RegWriteOut      = main_valid & main_entry[RW_BIT] &
                             (main_entry[WREG_LSB +: REG_W] != '0);

`ifdef EX_MEM_STAGE_FWD_EN
   // Loads (MemToReg) are excluded: their data is not known until after MEM.
   logic fwd_ok;
   assign fwd_ok  = OutValid & RegWriteOut & ~MemToRegOut;
   assign FwdHitA = fwd_ok & (WriteRegisterOut == FwdSrcA);
   assign FwdHitB = fwd_ok & (WriteRegisterOut == FwdSrcB);
   assign FwdData = ALUResultOut;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard testbench for ex_mem_stage
module tb_ex_mem_stage;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int PW     = 5 + REG_W + 2 * DATA_W;

   logic              Clock = 1'b0;
   logic              Reset = 1'b1;
   logic              Flush = 1'b0;
   logic              InValid = 1'b0;
   logic              InReady;
   logic              MemWriteIn = 1'b0, MemReadIn = 1'b0, BranchIn = 1'b0;
   logic              MemToRegIn = 1'b0, RegWriteIn = 1'b0;
   logic [REG_W-1:0]  WriteRegisterIn = '0;
   logic [DATA_W-1:0] ALUResultIn = '0, StoreDataIn = '0;
   logic              MemWriteOut, MemReadOut, BranchOut, MemToRegOut, RegWriteOut;
   logic [REG_W-1:0]  WriteRegisterOut;
   logic [DATA_W-1:0] ALUResultOut, StoreDataOut;
   logic              OutValid;
   logic              OutReady = 1'b0;
   logic [15:0]       StallCount;

   // Second instance with a 4-bit counter for saturation.
   logic              rst4 = 1'b1, inv4 = 1'b0, ordy4 = 1'b0;
   logic              irdy4, ov4;
   logic              mw4, mr4, br4, m2r4, rw4;
   logic [REG_W-1:0]  wreg4;
   logic [DATA_W-1:0] alu4, sd4;
   logic [3:0]        stall4;

`ifdef EX_MEM_STAGE_FWD_EN
   logic [REG_W-1:0]  FwdSrcA = '0, FwdSrcB = '0;
   logic              FwdHitA, FwdHitB, hit_a4, hit_b4;
   logic [DATA_W-1:0] FwdData, fwd4;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(16)) dut (
      .Clock(Clock), .Reset(Reset), .Flush(Flush),
      .InValid(InValid), .InReady(InReady),
      .MemWriteIn(MemWriteIn), .MemReadIn(MemReadIn), .BranchIn(BranchIn),
      .MemToRegIn(MemToRegIn), .RegWriteIn(RegWriteIn),
      .WriteRegisterIn(WriteRegisterIn), .ALUResultIn(ALUResultIn), .StoreDataIn(StoreDataIn),
      .MemWriteOut(MemWriteOut), .MemReadOut(MemReadOut), .BranchOut(BranchOut),
      .MemToRegOut(MemToRegOut), .RegWriteOut(RegWriteOut),
      .WriteRegisterOut(WriteRegisterOut), .ALUResultOut(ALUResultOut), .StoreDataOut(StoreDataOut),
      .OutValid(OutValid), .OutReady(OutReady), .StallCount(StallCount)
`ifdef EX_MEM_STAGE_FWD_EN
      , .FwdSrcA(FwdSrcA), .FwdSrcB(FwdSrcB), .FwdHitA(FwdHitA), .FwdHitB(FwdHitB), .FwdData(FwdData)
`endif
   );

   ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(4)) u_sat (
      .Clock(Clock), .Reset(rst4), .Flush(1'b0),
      .InValid(inv4), .InReady(irdy4),
      .MemWriteIn(MemWriteIn), .MemReadIn(MemReadIn), .BranchIn(BranchIn),
      .MemToRegIn(MemToRegIn), .RegWriteIn(RegWriteIn),
      .WriteRegisterIn(WriteRegisterIn), .ALUResultIn(ALUResultIn), .StoreDataIn(StoreDataIn),
      .MemWriteOut(mw4), .MemReadOut(mr4), .BranchOut(br4),
      .MemToRegOut(m2r4), .RegWriteOut(rw4),
      .WriteRegisterOut(wreg4), .ALUResultOut(alu4), .StoreDataOut(sd4),
      .OutValid(ov4), .OutReady(ordy4), .StallCount(stall4)
`ifdef EX_MEM_STAGE_FWD_EN
      , .FwdSrcA(FwdSrcA), .FwdSrcB(FwdSrcB), .FwdHitA(hit_a4), .FwdHitB(hit_b4), .FwdData(fwd4)
`endif
   );

   always #5 Clock = ~Clock;

   // ---------------- scoreboard monitor ----------------
   logic [PW-1:0] sb_q[$];
   logic [PW-1:0] sb_exp, sb_act;
   logic          mon_en = 1'b0;
   int            stall_exp = 0;

   always @(negedge Clock) begin
      if (mon_en) begin
         n_checks++;
         if (StallCount !== 16'(stall_exp)) begin
            n_fail++;
            $display("FAIL stall_count: got %0d expected %0d", StallCount, stall_exp);
         end
         if (Reset) begin
            sb_q.delete();
            stall_exp = 0;
         end else begin
            if (OutValid && !OutReady && stall_exp < 65535) stall_exp++;
            if (Flush) begin
               sb_q.delete();
            end else begin
               if (OutValid && OutReady) begin
                  n_checks++;
                  if (sb_q.size() == 0) begin
                     n_fail++;
                     $display("FAIL sb_unexpected: got alu=%h with no entry expected", ALUResultOut);
                  end else begin
                     sb_exp = sb_q.pop_front();
                     sb_act = {MemWriteOut, MemReadOut, BranchOut, MemToRegOut, RegWriteOut,
                               WriteRegisterOut, ALUResultOut, StoreDataOut};
                     if (sb_act !== sb_exp) begin
                        n_fail++;
                        $display("FAIL sb_data: got %h expected %h", sb_act, sb_exp);
                     end
                  end
               end
               if (InValid && InReady)
                  sb_q.push_back({MemWriteIn, MemReadIn, BranchIn, MemToRegIn,
                                  RegWriteIn & (WriteRegisterIn != '0),
                                  WriteRegisterIn, ALUResultIn, StoreDataIn});
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_in(input logic mw, input logic m2r, input logic rw,
                         input logic [REG_W-1:0] wreg, input logic [DATA_W-1:0] alu,
                         input logic [DATA_W-1:0] sd);
      MemWriteIn = mw; MemReadIn = m2r; BranchIn = 1'b0; MemToRegIn = m2r;
      RegWriteIn = rw; WriteRegisterIn = wreg; ALUResultIn = alu; StoreDataIn = sd;
   endtask

   task automatic set_rand();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      {MemWriteIn, MemReadIn, BranchIn, MemToRegIn, RegWriteIn,
       WriteRegisterIn, ALUResultIn, StoreDataIn} = r[PW-1:0];
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      Reset = 1'b1; InValid = 1'b1; OutReady = 1'b1; Flush = 1'b1;
      set_rand();
      tick(); tick();
      n_checks++;
      if ({OutValid, InReady, StallCount} !== {1'b0, 1'b1, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_hs: got ov=%b ir=%b sc=%0d expected 0 1 0", OutValid, InReady, StallCount);
      end
      n_checks++;
      if ({MemWriteOut, MemReadOut, BranchOut, MemToRegOut, RegWriteOut,
           WriteRegisterOut, ALUResultOut, StoreDataOut} !== '0) begin
         n_fail++;
         $display("FAIL reset_payload: got alu=%h sd=%h wreg=%0d expected all 0",
                  ALUResultOut, StoreDataOut, WriteRegisterOut);
      end
      Reset = 1'b0; InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0;
      stall_exp = 0;
      mon_en = 1'b1;
   endtask

   task automatic test_basic();
      OutReady = 1'b1;
      set_in(1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0);
      InValid = 1'b1;
      tick();
      InValid = 1'b0;
      n_checks++;
      if ({OutValid, ALUResultOut, RegWriteOut} !== {1'b1, 32'h1234, 1'b1}) begin
         n_fail++;
         $display("FAIL basic_latency: got ov=%b alu=%h rw=%b expected 1 1234 1",
                  OutValid, ALUResultOut, RegWriteOut);
      end
      tick();
      n_checks++;
      if (OutValid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_drain: got ov=%b expected 0", OutValid);
      end
   endtask

   task automatic test_stall();
      int sc0;
      sc0 = stall_exp;
      OutReady = 1'b0;
      set_in(1'b1, 1'b0, 1'b1, 5'd1, 32'hAAAA_0001, 32'h11);
      InValid = 1'b1;
      tick();
      set_in(1'b0, 1'b1, 1'b1, 5'd2, 32'hBBBB_0002, 32'h22);
      tick();
      InValid = 1'b0;
      n_checks++;
      if ({InReady, OutValid, ALUResultOut} !== {1'b0, 1'b1, 32'hAAAA_0001}) begin
         n_fail++;
         $display("FAIL stall_hold: got ir=%b ov=%b alu=%h expected 0 1 aaaa0001",
                  InReady, OutValid, ALUResultOut);
      end
      repeat (3) tick();
      n_checks++;
      if (StallCount !== 16'(sc0 + 4)) begin
         n_fail++;
         $display("FAIL stall_cycles: got %0d expected %0d", StallCount, sc0 + 4);
      end
      OutReady = 1'b1;
      tick();
      n_checks++;
      if ({InReady, OutValid, ALUResultOut} !== {1'b1, 1'b1, 32'hBBBB_0002}) begin
         n_fail++;
         $display("FAIL stall_skid_move: got ir=%b ov=%b alu=%h expected 1 1 bbbb0002",
                  InReady, OutValid, ALUResultOut);
      end
      tick();
      n_checks++;
      if (OutValid !== 1'b0 || StallCount !== 16'(sc0 + 4)) begin
         n_fail++;
         $display("FAIL stall_drain: got ov=%b sc=%0d expected 0 %0d", OutValid, StallCount, sc0 + 4);
      end
   endtask

   task automatic test_flush();
      // Both entries full, flush with input presented.
      OutReady = 1'b0;
      set_in(1'b1, 1'b0, 1'b1, 5'd3, 32'hC0C0_0003, 32'h33);
      InValid = 1'b1;
      tick();
      set_in(1'b1, 1'b0, 1'b1, 5'd4, 32'hD0D0_0004, 32'h44);
      tick();
      set_in(1'b1, 1'b0, 1'b1, 5'd6, 32'hEEEE_0005, 32'h55);
      Flush = 1'b1;
      tick();
      Flush = 1'b0; InValid = 1'b0;
      n_checks++;
      if ({OutValid, InReady, MemWriteOut} !== {1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL flush_full: got ov=%b ir=%b mw=%b expected 0 1 0", OutValid, InReady, MemWriteOut);
      end
      // Main full, skid empty: flushed input would otherwise be accepted.
      set_in(1'b1, 1'b0, 1'b1, 5'd8, 32'hF0F0_0006, 32'h66);
      InValid = 1'b1;
      tick();
      set_in(1'b1, 1'b0, 1'b1, 5'd9, 32'h9999_0007, 32'h77);
      Flush = 1'b1;
      tick();
      Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_discard: got ov=%b ir=%b alu=%h expected 0 1", OutValid, InReady, ALUResultOut);
         end
         tick();
      end
   endtask

   task automatic test_reg_zero();
      OutReady = 1'b0;
      set_in(1'b0, 1'b0, 1'b1, 5'd0, 32'h0BAD_0000, 32'h0);
      InValid = 1'b1;
      tick();
      InValid = 1'b0;
      n_checks++;
      if ({OutValid, RegWriteOut} !== {1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reg_zero: got ov=%b rw=%b expected 1 0", OutValid, RegWriteOut);
      end
      OutReady = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 400; i++) begin
         InValid  = ($urandom_range(0, 3) != 0);
         OutReady = ($urandom_range(0, 2) != 0);
         set_rand();
         tick();
      end
      InValid = 1'b0; OutReady = 1'b1;
      repeat (4) tick();
      n_checks++;
      if (sb_q.size() != 0 || OutValid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: got %0d pending ov=%b expected 0 0", sb_q.size(), OutValid);
      end
   endtask

   task automatic test_saturation();
      rst4 = 1'b1;
      tick();
      rst4 = 1'b0; ordy4 = 1'b0; inv4 = 1'b1;
      set_in(1'b0, 1'b0, 1'b1, 5'd10, 32'h5A5A_5A5A, 32'h0);
      tick();
      inv4 = 1'b0;
      repeat (20) tick();
      n_checks++;
      if (stall4 !== 4'd15 || ov4 !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_count: got sc=%0d ov=%b expected 15 1", stall4, ov4);
      end
      rst4 = 1'b1;
      tick();
      rst4 = 1'b0;
      n_checks++;
      if (stall4 !== 4'd0 || ov4 !== 1'b0 || irdy4 !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_reset: got sc=%0d ov=%b ir=%b expected 0 0 1", stall4, ov4, irdy4);
      end
   endtask

`ifdef EX_MEM_STAGE_FWD_EN
   task automatic test_forward();
      OutReady = 1'b0;
      set_in(1'b0, 1'b0, 1'b1, 5'd7, 32'h7777_0007, 32'h0);
      InValid = 1'b1;
      tick();
      InValid = 1'b0;
      FwdSrcA = 5'd7; FwdSrcB = 5'd3;
      #1;
      n_checks++;
      if ({FwdHitA, FwdHitB, FwdData} !== {1'b1, 1'b0, 32'h7777_0007}) begin
         n_fail++;
         $display("FAIL fwd_hit: got a=%b b=%b d=%h expected 1 0 77770007", FwdHitA, FwdHitB, FwdData);
      end
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      set_in(1'b0, 1'b1, 1'b1, 5'd7, 32'h7777_0008, 32'h0);
      InValid = 1'b1;
      tick();
      InValid = 1'b0;
      n_checks++;
      if ({OutValid, FwdHitA} !== {1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL fwd_load: got ov=%b a=%b expected 1 0", OutValid, FwdHitA);
      end
      OutReady = 1'b1;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_flush();
      test_reg_zero();
`ifdef EX_MEM_STAGE_FWD_EN
      test_forward();
`endif
      test_back_to_back();
      test_saturation();
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of ALU result and store data.
REQ-002 The block SHALL have parameter REG_W, default 5: width of destination register index.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of stall counter.
REQ-004 The block SHALL have port Clock  input  1: single clock; all state updates on rising edge.
REQ-005 The block SHALL have port Reset  input  1: synchronous, active-high reset.
REQ-006 The block SHALL have port Flush  input  1: synchronous discard of all held entries.
REQ-007 The block SHALL have ports InValid  input  1 and InReady  output  1: upstream (EX) handshake.
REQ-008 The block SHALL have ports MemWriteIn, MemReadIn, BranchIn, MemToRegIn, RegWriteIn  input  1 each: control bits.
REQ-009 The block SHALL have ports WriteRegisterIn  input  REG_W, ALUResultIn  input  DATA_W, StoreDataIn  input  DATA_W.
REQ-010 The block SHALL have matching outputs MemWriteOut, MemReadOut, BranchOut, MemToRegOut, RegWriteOut (1 each), WriteRegisterOut (REG_W), ALUResultOut and StoreDataOut (DATA_W).
REQ-011 The block SHALL have ports OutValid  output  1 and OutReady  input  1: downstream (MEM) handshake.
REQ-012 The block SHALL have port StallCount  output  CNT_W: count of cycles with OutValid=1 and OutReady=0.

Function
REQ-013 Storage SHALL be two entries: main (drives outputs) and skid; accept = InValid & InReady; release = OutValid & OutReady.
REQ-014 InReady SHALL be a registered signal equal to "skid entry empty"; it SHALL NOT depend combinationally on OutReady.
REQ-015 On accept with main empty or released that cycle and skid empty: input SHALL load into main; OutValid=1 next cycle (latency 1).
REQ-016 On accept with main valid and not released: input SHALL load into skid; InReady=0 next cycle.
REQ-017 On release with skid full: skid SHALL move into main that cycle; skid becomes empty; InReady=1 next cycle.
REQ-018 Order SHALL be preserved; no entry is lost or duplicated under any OutReady pattern.
REQ-019 Flush SHALL take priority over accept and release: both entries become invalid next cycle, input on the flush cycle is discarded, InReady=1 next cycle.
REQ-020 MemWriteOut, MemReadOut, BranchOut, RegWriteOut SHALL be 0 whenever OutValid=0.
REQ-021 RegWriteOut SHALL be 0 when WriteRegisterOut==0, regardless of the stored RegWrite bit.
REQ-022 StallCount SHALL increment by 1 per stall cycle, saturate at 2^CNT_W-1, and be unaffected by Flush.

Reset
REQ-023 Reset SHALL take priority over Flush and all handshakes; inputs are ignored while Reset=1.
REQ-024 After a reset cycle: OutValid=0, both entries invalid, InReady=1, StallCount=0, all payload and control outputs 0.

Configuration
REQ-025 Macro EX_MEM_STAGE_FWD_EN SHALL, when defined, add ports FwdSrcA, FwdSrcB (input, REG_W), FwdHitA, FwdHitB (output, 1), FwdData (output, DATA_W).
REQ-026 With EX_MEM_STAGE_FWD_EN: FwdHitX = OutValid & RegWriteOut & ~MemToRegOut & (WriteRegisterOut==FwdSrcX), combinational; FwdData = ALUResultOut.
REQ-027 Without EX_MEM_STAGE_FWD_EN the forwarding ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset, then InValid=1 with ALUResultIn=0x1234, WriteRegisterIn=5, RegWriteIn=1, OutReady=1 -> next cycle OutValid=1, ALUResultOut=0x1234, RegWriteOut=1.
REQ-029 OutReady=0, send A then B -> A held at outputs, InReady=0 after B; raise OutReady -> A then B, no loss; StallCount equals stall cycles.
REQ-030 Both entries full, Flush=1 with InValid=1 -> next cycle OutValid=0, InReady=1, MemWriteOut=0; flushed input never appears.
REQ-031 WriteRegisterIn=0, RegWriteIn=1 -> RegWriteOut=0 while OutValid=1.
REQ-032 CNT_W=4, hold OutReady=0 for 20 cycles -> StallCount=15; Reset -> 0.
REQ-033 With EX_MEM_STAGE_FWD_EN: held entry reg 7, RegWrite=1, MemToReg=0, FwdSrcA=7, FwdSrcB=3 -> FwdHitA=1, FwdHitB=0; set MemToReg=1 -> FwdHitA=0.
